// File: rtl/lms_pkg.sv
// rtl/lms_pkg.sv - shared LMS datapath widths and weight-increment saturation limits
package lms_pkg;

  localparam int LMS_PROD_W = 28;
  localparam int LMS_W_W    = 14;
  localparam int LMS_W_MAX  = (1 << (LMS_W_W - 1)) - 1;
  localparam int LMS_W_MIN  = -(1 << (LMS_W_W - 1));

endpackage

// File: rtl/lms_div.sv
// rtl/lms_div.sv - two-stage constant-divisor step scaler with signed saturation
module lms_div
  import lms_pkg::*;
#(
  parameter int IN_W    = LMS_PROD_W,
  parameter int OUT_W   = LMS_W_W,
  parameter int DIVISOR = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [IN_W-1:0]  in,
  output logic signed [OUT_W-1:0] out
);

  localparam int REM_W = IN_W - 1;
  localparam logic [IN_W-1:0]  DIV_FULL = IN_W'(DIVISOR);
  // Remainder stays below DIVISOR <= 2**(IN_W-1), so modular REM_W-bit subtraction is exact.
  localparam logic [REM_W-1:0] DIV_LO   = REM_W'(DIVISOR);
  localparam logic [IN_W-1:0]  POS_LIM  = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [IN_W-1:0]  NEG_LIM  = IN_W'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W - 1){1'b0}}};

  logic            sign;
  logic [IN_W-1:0] mag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign <= 1'b0;
      mag  <= '0;
    end else begin
      sign <= in[IN_W-1];
      mag  <= in[IN_W-1] ? -in : in;
    end
  end

  logic [IN_W-1:0] q;

  for (genvar g = 0; g < IN_W; g++) begin : g_div
    localparam int B = IN_W - 1 - g;
    logic [REM_W-1:0] rem_in;
    logic [IN_W-1:0]  trial;
    logic             qb;

    if (g == 0) begin : g_first
      assign rem_in = '0;
    end else begin : g_chain
      assign rem_in = g_div[g-1].g_next.rem_out;
    end

    assign trial = {rem_in, mag[B]};
    assign qb    = (trial >= DIV_FULL);
    assign q[B]  = qb;

    // The final remainder is discarded, so the last stage produces none.
    if (g < IN_W - 1) begin : g_next
      logic [REM_W-1:0] rem_out;
      assign rem_out = qb ? (trial[REM_W-1:0] - DIV_LO) : trial[REM_W-1:0];
    end
  end

  logic [OUT_W-1:0] q_lo;
  logic [OUT_W-1:0] sat;

  assign q_lo = q[OUT_W-1:0];

  always_comb begin
    sat = sign ? -q_lo : q_lo;
    if (!sign && (q > POS_LIM)) begin
      sat = OUT_MAX;
    end else if (sign && (q > NEG_LIM)) begin
      sat = OUT_MIN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= '0;
    end else begin
      out <= sat;
    end
  end

endmodule

// File: tb/tb_lms_div.sv
// tb/tb_lms_div.sv - randomized and directed check of lms_div against a quotient-and-clamp model
module tb_lms_div;
  import lms_pkg::*;

  localparam int IW = LMS_PROD_W;
  localparam int OW = LMS_W_W;

  logic                 clk  = 1'b0;
  logic                 rstn = 1'b0;
  logic signed [IW-1:0] in_v = '0;
  logic signed [OW-1:0] out_a;
  logic signed [OW-1:0] out_b;
  logic signed [OW-1:0] out_c;

  int nerr = 0;
  int nchk = 0;

  lms_div #(.IN_W(IW), .OUT_W(OW), .DIVISOR(1024)) dut_a (.clk(clk), .rstn(rstn), .in(in_v), .out(out_a));
  lms_div #(.IN_W(IW), .OUT_W(OW), .DIVISOR(1))    dut_b (.clk(clk), .rstn(rstn), .in(in_v), .out(out_b));
  lms_div #(.IN_W(IW), .OUT_W(OW), .DIVISOR(3))    dut_c (.clk(clk), .rstn(rstn), .in(in_v), .out(out_c));

  always #5 clk = ~clk;

  function automatic int model(input int x, input int d);
    int q;
    q = x / d;
    if (q > LMS_W_MAX) q = LMS_W_MAX;
    if (q < LMS_W_MIN) q = LMS_W_MIN;
    return q;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Edge log: an output after edge m reflects the input at edge m-1, unless reset intervened.
  int ecount   = 0;
  int last_low = 0;
  int rec[0:16383];
  bit chk_on   = 1'b0;

  always @(negedge rstn) last_low = ecount;

  always @(posedge clk) begin
    int  x;
    bit  live;
    ecount++;
    rec[ecount % 16384] = int'(in_v);
    if (!rstn) last_low = ecount;
    #1;
    if (chk_on) begin
      live = (ecount - 1 >= last_low + 1);
      x    = rec[(ecount - 1) % 16384];
      check("cmp_div1024", int'(out_a), live ? model(x, 1024) : 0);
      check("cmp_div1",    int'(out_b), live ? model(x, 1)    : 0);
      check("cmp_div3",    int'(out_c), live ? model(x, 3)    : 0);
    end
  end

  int dir_in[10]  = '{-10240, 1023, -1023, 134217727, -134217728,
                      8389631, -8388608, 8388608, -8389632, -8389631};
  int dir_exp[10] = '{-10, 0, 0, 8191, -8192, 8191, -8192, 8191, -8192, -8192};
  int str_in[10];

  initial begin
    int r;
    check("model_pos",   model(10240, 1024), 10);
    check("model_trunc", model(-1023, 1024), 0);
    check("model_satn",  model(-134217728, 1024), -8192);
    check("model_div3",  model(-7, 3), -2);
    check("model_div1",  model(20000, 1), 8191);

    repeat (3) @(posedge clk);
    #2;
    check("reset_a", int'(out_a), 0);
    check("reset_b", int'(out_b), 0);
    check("reset_c", int'(out_c), 0);
    @(negedge clk);
    rstn   = 1'b1;
    chk_on = 1'b1;

    @(negedge clk) in_v = IW'(10240);
    @(posedge clk); #2;
    check("t1_before", int'(out_a), 0);
    @(posedge clk); #2;
    check("t1_after", int'(out_a), 10);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk) in_v = IW'(dir_in[i]);
      @(posedge clk);
      @(posedge clk); #2;
      check($sformatf("directed_%0d", dir_in[i]), int'(out_a), dir_exp[i]);
    end

    for (int i = 0; i < 10; i++) str_in[i] = ((i % 4) == 3 ? -i : i) * 1024;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) in_v = IW'(str_in[i]);
      @(posedge clk); #2;
      if (i >= 1) check($sformatf("stream_%0d", i - 1), int'(out_a), str_in[i-1] / 1024);
    end
    @(posedge clk); #2;
    check("stream_9", int'(out_a), str_in[9] / 1024);

    @(negedge clk) in_v = IW'(7 * 1024);
    @(posedge clk);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check("t5_async", int'(out_a), 0);
    @(posedge clk); #2;
    check("t5_held", int'(out_a), 0);
    @(negedge clk);
    in_v = IW'(5120);
    rstn = 1'b1;
    @(posedge clk); #2;
    check("t5_edge1", int'(out_a), 0);
    @(posedge clk); #2;
    check("t5_edge2", int'(out_a), 5);

    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       r = int'($signed(IW'($urandom)));
        1:       r = $urandom_range(0, 32767) - 16384;
        2:       r = 8388608 + $urandom_range(0, 6000) - 3000;
        default: r = -8388608 + $urandom_range(0, 6000) - 3000;
      endcase
      in_v = IW'(r);
      if ($urandom_range(0, 1999) == 0) rstn = 1'b0;
      else rstn = 1'b1;
    end
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
